blk_addr_gen: RTL

Multi-channel block address generator, the parametrised successor of the single-channel IDLE / GEN_BLK_ADDR / WAITO sequencer. Up to NUM_CH requesters raise `get_data`. A round-robin arbiter grants one channel, and the block emits a burst of BLK_LEN addresses from that channel's base address with a valid/ready handshake. It then waits for downstream completion before returning to IDLE. It sits between the request logic and the memory read port.

---
 rtl/blk_addr_gen_pkg.sv | 27 ++
 rtl/blk_addr_gen_rr_arbiter.sv | 36 +++
 rtl/blk_addr_gen.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/blk_addr_gen_pkg.sv
// Shared types for blk_addr_gen: state encoding and the round-robin pointer helper.
package blk_addr_gen_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'b00,
        WAITO        = 2'b01,
        GEN_BLK_ADDR = 2'b11
    } state_t;

    localparam int unsigned MaxCh = 16;

    // Pointer after granting the first requester at or after ptr (wrapping); ptr if none.
    function automatic int unsigned next_rr(input int unsigned ptr, input logic [MaxCh-1:0] req,
                                            input int unsigned n);
        int unsigned j;
        logic [MaxCh-1:0] sh;
        for (int unsigned i = 0; i < MaxCh; i++) begin
            j  = (ptr + i) % n;
            sh = req >> j;
            if (i < n && sh[0]) begin
                return (j + 1 == n) ? 0 : j + 1;
            end
        end
        return ptr;
    endfunction

endpackage

// File: rtl/blk_addr_gen_rr_arbiter.sv
// Round-robin arbiter: first set request at or after ptr, wrapping; one-hot and binary outputs.
module rr_arbiter #(
    parameter int unsigned N = 4,
    localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    req,
    input  logic [IdxW-1:0] ptr,
    output logic [N-1:0]    gnt,
    output logic [IdxW-1:0] idx
);
    localparam int unsigned SumW = IdxW + 1;

    logic [2*N-1:0]  req_dbl;
    logic [N-1:0]    req_rot;
    logic [IdxW-1:0] off;
    logic [SumW-1:0] idx_sum;
    logic            found;

    always_comb begin
        // Rotate so that bit 0 is the channel at ptr; then a plain priority search suffices.
        req_dbl = {req, req} >> ptr;
        req_rot = req_dbl[N-1:0];
        found   = 1'b0;
        off     = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (!found && req_rot[i]) begin
                found = 1'b1;
                off   = IdxW'(i);
            end
        end
        idx_sum = {1'b0, ptr} + {1'b0, off};
        idx     = (idx_sum >= SumW'(N)) ? IdxW'(idx_sum - SumW'(N)) : IdxW'(idx_sum);
        gnt     = found ? (N'(1) << idx) : '0;
    end

endmodule

// File: rtl/blk_addr_gen.sv
// Multi-channel block address generator: round-robin grant, BLK_LEN-beat burst, wait for done.
// Define BLK_ADDR_GEN_ASSERT_EN to compile the embedded assertions and covers.
module blk_addr_gen
    import blk_addr_gen_pkg::*;
#(
    parameter int unsigned NUM_CH  = 4,
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned BLK_LEN = 64,
    parameter int unsigned STRIDE  = 1,
    localparam int unsigned ChW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        get_data,
    input  logic [NUM_CH*ADDR_W-1:0] base_addr,
    input  logic                     addr_ready,
    input  logic                     blk_done,
    output logic [1:0]               cs,
    output logic                     addr_valid,
    output logic [ADDR_W-1:0]        addr,
    output logic                     addr_last,
    output logic [ChW-1:0]           ch_id,
    output logic [NUM_CH-1:0]        grant
);
    localparam int unsigned CntW = $clog2(BLK_LEN);
    localparam logic [CntW-1:0] LastBeat   = CntW'(BLK_LEN - 1);
    localparam logic [CntW-1:0] LastBeatM1 = CntW'(BLK_LEN - 2);

    state_t            cs_q, cs_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              addr_last_q, addr_last_d;
    logic [ChW-1:0]    ch_id_q, ch_id_d;
    logic [ChW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [CntW-1:0]   beat_cnt_q, beat_cnt_d;

    logic [NUM_CH-1:0] arb_gnt;
    logic [ChW-1:0]    arb_idx;
    logic [ADDR_W-1:0] base_sel;

    rr_arbiter #(
        .N(NUM_CH)
    ) u_arb (
        .req(get_data),
        .ptr(rr_ptr_q),
        .gnt(arb_gnt),
        .idx(arb_idx)
    );

    always_comb begin
        base_sel = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (arb_idx == ChW'(k)) base_sel = base_addr[k*ADDR_W +: ADDR_W];
        end
    end

    always_comb begin
        cs_d        = cs_q;
        addr_d      = addr_q;
        addr_last_d = addr_last_q;
        ch_id_d     = ch_id_q;
        rr_ptr_d    = rr_ptr_q;
        beat_cnt_d  = beat_cnt_q;
        grant       = '0;
        case (cs_q)
            IDLE: begin
                if (|get_data) begin
                    // Reset has priority, so no grant is advertised while it is held.
                    grant       = rst ? '0 : arb_gnt;
                    ch_id_d     = arb_idx;
                    addr_d      = base_sel;
                    rr_ptr_d    = ChW'(next_rr(32'(rr_ptr_q), MaxCh'(get_data), NUM_CH));
                    beat_cnt_d  = '0;
                    addr_last_d = 1'b0;
                    cs_d        = GEN_BLK_ADDR;
                end
            end
            GEN_BLK_ADDR: begin
                if (addr_ready) begin
                    addr_d = addr_q + ADDR_W'(STRIDE);
                    if (beat_cnt_q == LastBeat) begin
                        beat_cnt_d  = '0;
                        addr_last_d = 1'b0;
                        cs_d        = WAITO;
                    end else begin
                        beat_cnt_d  = beat_cnt_q + CntW'(1);
                        addr_last_d = (beat_cnt_q == LastBeatM1);
                    end
                end
            end
            WAITO: begin
                if (blk_done) cs_d = IDLE;
            end
            default: cs_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cs_q        <= IDLE;
            addr_q      <= '0;
            addr_last_q <= 1'b0;
            ch_id_q     <= '0;
            rr_ptr_q    <= '0;
            beat_cnt_q  <= '0;
        end else begin
            cs_q        <= cs_d;
            addr_q      <= addr_d;
            addr_last_q <= addr_last_d;
            ch_id_q     <= ch_id_d;
            rr_ptr_q    <= rr_ptr_d;
            beat_cnt_q  <= beat_cnt_d;
        end
    end

    assign cs         = cs_q;
    assign addr_valid = (cs_q == GEN_BLK_ADDR);
    assign addr       = addr_q;
    assign addr_last  = addr_last_q;
    assign ch_id      = ch_id_q;

`ifdef BLK_ADDR_GEN_ASSERT_EN
    a_legal_cs: assert property (@(posedge clk) disable iff (rst) cs != 2'b10);
    c_legal_cs: cover property (@(posedge clk) disable iff (rst) cs != 2'b10);

    a_grant_1h: assert property (@(posedge clk) disable iff (rst) $onehot0(grant));
    c_grant_1h: cover property (@(posedge clk) disable iff (rst) $onehot(grant));

    a_go: assert property (@(posedge clk) disable iff (rst)
        (cs == IDLE && |get_data) |=> cs == GEN_BLK_ADDR);
    c_go: cover property (@(posedge clk) disable iff (rst) (cs == IDLE && |get_data));

    a_burst: assert property (@(posedge clk) disable iff (rst)
        (cs == IDLE && |get_data) ##1 (addr_ready && cs == GEN_BLK_ADDR)[*BLK_LEN]
        |=> cs == WAITO);
    c_burst: cover property (@(posedge clk) disable iff (rst)
        (cs == IDLE && |get_data) ##1 (addr_ready && cs == GEN_BLK_ADDR)[*BLK_LEN]);

    a_hold: assert property (@(posedge clk) disable iff (rst)
        (addr_valid && !addr_ready) |=> $stable(addr));
    c_hold: cover property (@(posedge clk) disable iff (rst) (addr_valid && !addr_ready));

    a_last_valid: assert property (@(posedge clk) disable iff (rst) addr_last |-> addr_valid);
    c_last_valid: cover property (@(posedge clk) disable iff (rst) addr_last);
`endif

endmodule
